// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue sequencer and its funct decoder.
// Holds the ALU op-select encoding (shared with the ALU), the MIPS R-type
// funct codes that map onto it, and the sequencer FSM state encoding.
package alu_issue_seq_pkg;

  // ALU op-select encoding, shared with the ALU
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  // MIPS R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational MIPS funct -> ALU op-select decoder.
// Ports:
//   funct   in  6  MIPS R-type funct code
//   op      out 3  ALU op select (OP_AND when illegal)
//   illegal out 1  funct is not a supported ALU operation
module alu_funct_decode
  import alu_issue_seq_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] op,
  output logic       illegal
);

  always_comb begin
    op      = OP_AND;
    illegal = 1'b0;
    case (funct)
      FUNCT_AND: op = OP_AND;
      FUNCT_OR:  op = OP_OR;
      FUNCT_ADD: op = OP_ADD;
      FUNCT_SUB: op = OP_SUB;
      FUNCT_NOR: op = OP_NOR;
      FUNCT_SLT: op = OP_SLT;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Sequencing front end for the external combinational ALU.
// Accepts a funct/operand request, drives the ALU from registers, captures the
// ALU result one cycle later and returns it over a valid/ready response port.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_funct, req_a, req_b payload
//   rsp_valid/rsp_ready   response handshake; rsp_data, rsp_zero, rsp_err payload
//   alu_a, alu_b, alu_op  registered ALU inputs
//   alu_s, alu_z          ALU result and zero flag
//   op_count              count of non-error responses delivered (wraps)
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_z,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [2:0] dec_op;
  logic       dec_illegal;

  alu_funct_decode u_decode (
    .funct   (req_funct),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    op_count_d = op_count_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (dec_illegal) begin
            // Errors skip the ALU entirely; its inputs keep their last values
            rsp_data_d = '0;
            rsp_zero_d = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = StResp;
          end else begin
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            alu_op_d = dec_op;
            state_d  = StExec;
          end
        end
      end
      StExec: begin
        rsp_data_d = alu_s;
        rsp_zero_d = alu_z;
        rsp_err_d  = 1'b0;
        state_d    = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
          if (!rsp_err_q) op_count_d = op_count_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_data = rsp_data_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err  = rsp_err_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq with a behavioural ALU. Expected responses are
// queued at issue time and popped by a monitor on each response handshake.
module tb_alu_issue_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [5:0]       req_funct = '0;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_s;
  logic             alu_z;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
  } rsp_t;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_issue_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_funct (req_funct),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_s     (alu_s),
    .alu_z     (alu_z),
    .op_count  (op_count)
  );

  // Behavioural ALU
  always_comb begin
    alu_s = '0;
    case (alu_op)
      3'd0: alu_s = alu_a & alu_b;
      3'd1: alu_s = alu_a | alu_b;
      3'd2: alu_s = alu_a + alu_b;
      3'd3: alu_s = alu_a - alu_b;
      3'd4: alu_s = ~(alu_a | alu_b);
      3'd5: alu_s = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_s = '0;
    endcase
    alu_z = (alu_s == '0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on each handshake; check payload stability while stalled
  logic             held = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic             held_zero, held_err;
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (held) begin
        chk("stall_data", rsp_data, held_data);
        chk("stall_zero", 32'(rsp_zero), 32'(held_zero));
        chk("stall_err", 32'(rsp_err), 32'(held_err));
      end
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
    held      = !rst && rsp_valid && !rsp_ready;
    held_data = rsp_data;
    held_zero = rsp_zero;
    held_err  = rsp_err;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait (bounded) for its acceptance edge
  task automatic accept(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    req_valid = 1'b1;
    req_funct = funct;
    req_a     = a;
    req_b     = b;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1;
        step();
        break;
      end
      step();
    end
    req_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Full transaction: valid ops check EXEC latency, errors check 1-cycle latency
  task automatic do_op(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] exp_op, input logic [31:0] exp_data,
                       input logic exp_zero, input logic exp_err, input int stall);
    logic [2:0]  op_before;
    logic [31:0] a_before;
    rsp_t e;
    op_before = alu_op;
    e.data = exp_data;
    e.zero = exp_zero;
    e.err  = exp_err;
    exp_q.push_back(e);
    accept(funct, a, b);
    if (exp_err) begin
      chk("err_alu_op_kept", 32'(alu_op), 32'(op_before));
    end else begin
      chk("exec_alu_op", 32'(alu_op), 32'(exp_op));
      chk("exec_alu_a", alu_a, a);
      chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    a_before = alu_a;
    for (int i = 0; i < stall; i++) begin
      // A competing request must not be taken while the response is pending
      req_valid = 1'b1;
      req_funct = 6'h20;
      req_a     = 32'hDEAD_BEEF;
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      step();
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_alu_a", alu_a, a_before);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (!exp_err) exp_count = (exp_count + 1) % 4;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("op_count", 32'(op_count), 32'(exp_count));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);

    do_op(6'h20, 32'd5, 32'd7, 3'd2, 32'd12, 1'b0, 1'b0, 0);
    do_op(6'h22, 32'h1234, 32'h1234, 3'd3, 32'd0, 1'b1, 1'b0, 0);
    do_op(6'h00, 32'd9, 32'd9, 3'd0, 32'd0, 1'b0, 1'b1, 0);
    do_op(6'h24, 32'hF0F0, 32'hFF00, 3'd0, 32'hF000, 1'b0, 1'b0, 5);

    // Reset while a NOR is in EXEC: no response may appear
    accept(6'h27, 32'h1, 32'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 0;
    chk("rrst_req_ready", 32'(req_ready), 32'd1);
    chk("rrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rrst_rsp_data", rsp_data, 32'd0);
    chk("rrst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rrst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rrst_alu_a", alu_a, 32'd0);
    chk("rrst_alu_b", alu_b, 32'd0);
    chk("rrst_alu_op", 32'(alu_op), 32'd0);
    chk("rrst_op_count", 32'(op_count), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rrst_quiet", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;

    // Counter wrap with CNT_W=2: 1, 2, 3, 0, 1
    do_op(6'h25, 32'd1, 32'd2, 3'd1, 32'd3, 1'b0, 1'b0, 0);
    do_op(6'h2A, 32'hFFFF_FFFF, 32'd1, 3'd5, 32'd1, 1'b0, 1'b0, 1);
    do_op(6'h21, 32'd3, 32'd4, 3'd0, 32'd0, 1'b0, 1'b1, 2);
    do_op(6'h27, 32'd0, 32'd0, 3'd4, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    do_op(6'h20, 32'hFFFF_FFFF, 32'd1, 3'd2, 32'd0, 1'b1, 1'b0, 0);
    do_op(6'h22, 32'd10, 32'd3, 3'd3, 32'd7, 1'b0, 1'b0, 0);

    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Sequencing front end for the 32-bit combinational ALU. It accepts R-type operation requests (MIPS funct code plus two operands) over a valid/ready handshake and decodes the funct code to the ALU's 3-bit operation select. It drives the ALU's operand and op inputs from registers, captures the ALU result and zero flag one cycle later, and returns them over a valid/ready response port. It sits between the datapath controller and the ALU and owns all ALU control-side traffic.

## Interface
- WIDTH, 32: operand/result width.
- CNT_W, 16: width of the completed-operation counter.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_funct  in  6  MIPS funct code.
- req_a, req_b  in  WIDTH  operands.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  captured ALU result.
- rsp_zero  out  1  captured ALU zero flag.
- rsp_err  out  1  unsupported funct.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_op  out  3  registered op select to the ALU.
- alu_s  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_z  in  1  ALU zero flag (1 when alu_s == 0).
- op_count  out  CNT_W  number of successful (non-error) responses delivered.

## Operation
- Funct decode to alu_op: 0x24 -> 0 (AND), 0x25 -> 1 (OR), 0x20 -> 2 (ADD), 0x22 -> 3 (SUB), 0x27 -> 4 (NOR), 0x2A -> 5 (SLT). Any other funct is an error.
- FSM states:
  - IDLE: req_ready=1. On req_valid, the request is accepted.
    - Valid funct: load alu_a, alu_b, alu_op; go to EXEC.
    - Invalid funct: load rsp_data=0, rsp_zero=0, rsp_err=1; go to RESP. alu_* registers are unchanged.
  - EXEC: req_ready=0. Capture rsp_data<=alu_s, rsp_zero<=alu_z, rsp_err<=0; go to RESP.
  - RESP: rsp_valid=1. On rsp_ready go to IDLE. If rsp_err==0, op_count increments, wrapping modulo 2^CNT_W.
- rsp_data, rsp_zero and rsp_err hold stable while rsp_valid=1 and rsp_ready=0.
- alu_a, alu_b and alu_op hold their last values after EXEC; they are not cleared.
- The block performs no arithmetic itself. Result width and SLT/overflow semantics are the ALU's.

## Timing
- Reset values:
  - State IDLE.
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_op=0, op_count=0.
- Valid request accepted at edge E0: alu_* are updated after E0. Result is captured at E1. rsp_valid is high from after E1 until the edge where rsp_ready=1.
- Error request accepted at E0: rsp_valid is high from after E0.
- Minimum spacing between accepted requests is 3 cycles (2 for errors). req_ready is low from after the acceptance edge until RESP completes.
- rsp_ready=1 at the first RESP cycle: exactly one rsp_valid cycle, then IDLE. The next request can be accepted at the following edge.
- req_valid while req_ready=0 is ignored. The requester must hold it.
- rsp_ready outside RESP is ignored.
- rst asserted in any state: the in-flight operation is discarded with no response, all registers take reset values at that edge, and op_count clears.
- op_count wraps from 2^CNT_W-1 to 0.

## Structure
- Shared package holds:
  - ALU op constants OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=3, OP_NOR=4, OP_SLT=5, shared with the ALU.
  - MIPS funct constants.
  - FSM state encoding IDLE/EXEC/RESP.
- One combinational sub-module, alu_funct_decode: funct in; op and illegal flag out. It is reused by the main control unit.
- The ALU is instantiated outside this block. Benches connect a behavioural ALU model.

## Test plan
- Reset, then ADD with a=5, b=7 -> alu_op=2. rsp_valid is high 2 cycles after acceptance with rsp_data=12, rsp_zero=0, rsp_err=0. op_count=1 after the response handshake.
- SUB with a=b=0x1234 -> rsp_data=0, rsp_zero=1.
- funct=0x00 -> rsp_valid 1 cycle after acceptance with rsp_err=1, rsp_data=0. alu_op is unchanged and op_count is unchanged.
- rsp_ready held low for 5 cycles after an AND with a=0xF0F0, b=0xFF00 -> rsp_data=0xF000 is held stable for all 5 cycles. req_ready=0 throughout, and a second req_valid is not accepted.
- rst asserted during EXEC of a NOR -> no response is produced. All outputs are at reset values on the next cycle and req_ready=1.
- CNT_W=2, five successful ops -> op_count sequence 1, 2, 3, 0, 1.
